mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Round-robin scheduler that shares one stb/ack floating-point `multiplier` instance among NREQ requesters. It accepts an operand pair from the granted requester and drives the multiplier's A, B and Z handshakes in sequence. It returns the product to that requester through a result handshake. A watchdog aborts a hung multiplier, resets it, and returns an error result so that no requester is starved.

## Interface
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 1000: maximum cycles from entering SEND_A until mul_z_stb before abort.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- req_a  input  NREQ*32  operand A per requester, slice i = [32*i+31:32*i].
- req_b  input  NREQ*32  operand B per requester.
- req_stb  input  NREQ  requester i presents an operand pair.
- req_ack  output  NREQ  one-cycle pulse: pair from requester i accepted.
- rsp_z  output  32  result for the requester currently being answered.
- rsp_err  output  1  qualifies rsp_z: 1 = aborted by timeout.
- rsp_stb  output  NREQ  result valid for requester i.
- rsp_ack  input  NREQ  requester i accepts the result.
- mul_rst  output  1  active-high reset to the multiplier.
- mul_a, mul_b  output  32 each  multiplier operands.
- mul_a_stb, mul_b_stb  output  1 each  operand strobes.
- mul_a_ack, mul_b_ack  input  1 each  operand acks from the multiplier.
- mul_z  input  32  multiplier product.
- mul_z_stb  input  1  product valid.
- mul_z_ack  output  1  product accepted.

## Operation
- A handshake transfer occurs on the rising edge at which stb and ack are both 1.
- States are IDLE, SEND_A, SEND_B, WAIT_Z, ACK_Z, RESP and RECOVER.
- IDLE:
  - If any req_stb is set, grant the first set bit searching from ptr upward with wrap-around.
  - Latch a, b and id, and set ptr = (id+1) mod NREQ.
  - Pulse req_ack[id] high for the next cycle, then go to SEND_A.
  - req_stb is ignored outside IDLE.
- SEND_A: mul_a = latched a, mul_a_stb = 1. On transfer, drop the strobe and go to SEND_B.
- SEND_B: the same as SEND_A for B. On transfer, go to WAIT_Z.
- WAIT_Z: on mul_z_stb = 1, latch mul_z and go to ACK_Z.
- ACK_Z: mul_z_ack = 1 for exactly one cycle, then go to RESP with err = 0.
- RESP:
  - rsp_stb[id] = 1, rsp_z = latched z, rsp_err = err.
  - Hold until rsp_ack[id] transfers, then go to IDLE.
  - rsp_ack on other bits is ignored.
- Watchdog:
  - A counter clears in IDLE and increments each cycle in SEND_A, SEND_B and WAIT_Z.
  - When it reaches TIMEOUT, drop all mul strobes and go to RECOVER.
- RECOVER:
  - mul_rst = 1 for 2 cycles.
  - Then go to RESP with z = 0x7FC00000 (quiet NaN) and err = 1.
- Only one operation is in flight at any time. No requester waits more than NREQ-1 operations after its strobe is seen.

## Timing
- Reset values: state IDLE, ptr 0, counter 0, all outputs 0. mul_rst also reads 0 while rst is low, and the multiplier is reset externally.
- The best case with a zero-wait multiplier is as follows, where edge E is the edge at which IDLE sees req_stb:
  - req_ack is high in the cycle after E.
  - mul_a_stb is high in the same cycle.
  - rsp_stb rises 2 cycles after mul_z_stb is seen.
- Requester rules:
  - A requester must hold req_stb and its operands stable until req_ack.
  - It must deassert req_stb at or before the edge following req_ack, or it is re-granted.
- The arbiter may sample req_stb in the same cycle it returns to IDLE.
- If several requests arrive together, grant order follows ptr. After serving id 2 with NREQ = 4, priority is 3, 0, 1, 2.
- If rst is asserted mid-operation, all state clears immediately. The latched pair and any pending result are lost, with no rsp_stb.
- rsp_stb may be held indefinitely. The watchdog does not run in RESP.

## Test plan
- Single request on requester 0 with a = 0x40000000 and b = 0x40400000 -> one req_ack[0] pulse, then rsp_stb[0] with rsp_z = 0x40C00000 and rsp_err = 0.
- Requesters 0..3 all strobe in the same cycle with distinct pairs (for example 0x3FC00000×0x3FC00000 = 0x40100000 and 0xBF800000×0x40800000 = 0xC0800000) -> grants in order 0, 1, 2, 3, each result routed only to its own rsp_stb bit.
- Requester 1 streams continuously while requester 2 strobes once -> requester 2 is served after at most one requester-1 operation.
- Multiplier model never asserts mul_z_stb -> after TIMEOUT cycles, mul_rst is high for 2 cycles, then rsp_z = 0x7FC00000 with rsp_err = 1. The next request completes normally.
- rsp_ack is held low for 50 cycles -> rsp_stb stays high, no new grant occurs and no timeout fires. After the ack, the next pending request is granted.
- rst is driven low during WAIT_Z -> all outputs are 0 immediately and no response is produced. After release, a fresh request is served with ptr back at 0.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin front end that time-shares one stb/ack floating-point multiplier
// among NREQ requesters, with a watchdog that recovers from a hung multiplier.
module mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_stb,
  output logic [NREQ-1:0]      req_ack,
  output logic [31:0]          rsp_z,
  output logic                 rsp_err,
  output logic [NREQ-1:0]      rsp_stb,
  input  logic [NREQ-1:0]      rsp_ack,
  output logic                 mul_rst,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_a_stb,
  output logic                 mul_b_stb,
  input  logic                 mul_a_ack,
  input  logic                 mul_b_ack,
  input  logic [31:0]          mul_z,
  input  logic                 mul_z_stb,
  output logic                 mul_z_ack
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE, SEND_A, SEND_B, WAIT_Z, ACK_Z, RESP, RECOVER
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   id;
  logic [CW-1:0]   cnt;
  logic            rcnt;
  logic [31:0]     z_lat;

  logic            gnt_vld;
  logic [IW-1:0]   gnt_id;
  logic [IW-1:0]   ptr_nxt;
  logic            abort;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_stb[IW'(j)]) begin
        gnt_vld = 1'b1;
        gnt_id  = IW'(j);
      end
    end
  end

  assign ptr_nxt = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);

  // A product arriving in the last allowed cycle still counts as on time.
  assign abort = (state inside {SEND_A, SEND_B, WAIT_Z}) &&
                 (cnt == CW'(TIMEOUT - 1)) &&
                 !(state == WAIT_Z && mul_z_stb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      rcnt      <= 1'b0;
      z_lat     <= '0;
      req_ack   <= '0;
      rsp_z     <= '0;
      rsp_err   <= 1'b0;
      rsp_stb   <= '0;
      mul_rst   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      mul_z_ack <= 1'b0;
    end else begin
      req_ack <= '0;
      if (abort) begin
        mul_a_stb <= 1'b0;
        mul_b_stb <= 1'b0;
        mul_rst   <= 1'b1;
        rcnt      <= 1'b0;
        state     <= RECOVER;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (gnt_vld) begin
              id              <= gnt_id;
              ptr             <= ptr_nxt;
              mul_a           <= req_a[{gnt_id, 5'd0} +: 32];
              mul_b           <= req_b[{gnt_id, 5'd0} +: 32];
              req_ack[gnt_id] <= 1'b1;
              mul_a_stb       <= 1'b1;
              state           <= SEND_A;
            end
          end
          SEND_A: begin
            cnt <= cnt + CW'(1);
            if (mul_a_ack) begin
              mul_a_stb <= 1'b0;
              mul_b_stb <= 1'b1;
              state     <= SEND_B;
            end
          end
          SEND_B: begin
            cnt <= cnt + CW'(1);
            if (mul_b_ack) begin
              mul_b_stb <= 1'b0;
              state     <= WAIT_Z;
            end
          end
          WAIT_Z: begin
            cnt <= cnt + CW'(1);
            if (mul_z_stb) begin
              z_lat     <= mul_z;
              mul_z_ack <= 1'b1;
              state     <= ACK_Z;
            end
          end
          ACK_Z: begin
            mul_z_ack   <= 1'b0;
            rsp_stb[id] <= 1'b1;
            rsp_z       <= z_lat;
            rsp_err     <= 1'b0;
            state       <= RESP;
          end
          RESP: begin
            if (rsp_ack[id]) begin
              rsp_stb <= '0;
              rsp_z   <= '0;
              rsp_err <= 1'b0;
              state   <= IDLE;
            end
          end
          RECOVER: begin
            if (rcnt) begin
              mul_rst     <= 1'b0;
              rsp_stb[id] <= 1'b1;
              rsp_z       <= QNAN;
              rsp_err     <= 1'b1;
              state       <= RESP;
            end else begin
              rcnt <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a table-driven zero-wait multiplier model.
module tb_mul_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 40;
  localparam int NTAB    = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ*32-1:0]  req_a = '0, req_b = '0;
  logic [NREQ-1:0]     req_stb = '0, rsp_ack = '0;
  logic [NREQ-1:0]     req_ack, rsp_stb;
  logic [31:0]         rsp_z;
  logic                rsp_err;
  logic                mul_rst;
  logic [31:0]         mul_a, mul_b, mul_z;
  logic                mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;

  always #5 clk = ~clk;

  mul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .rsp_z(rsp_z), .rsp_err(rsp_err), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
    .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack)
  );

  // IEEE-754 single products worked out by hand.
  logic [31:0] tab_a [NTAB] = '{32'h40000000, 32'h3FC00000, 32'hBF800000, 32'h40800000,
                                32'h3F800000, 32'h40400000, 32'h3F000000, 32'h40A00000};
  logic [31:0] tab_b [NTAB] = '{32'h40400000, 32'h3FC00000, 32'h40800000, 32'h40000000,
                                32'h3F800000, 32'h40400000, 32'h40800000, 32'h40000000};
  logic [31:0] tab_z [NTAB] = '{32'h40C00000, 32'h40100000, 32'hC0800000, 32'h41000000,
                                32'h3F800000, 32'h41100000, 32'h40000000, 32'h41200000};

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    fmul = 32'hDEADBEEF;
    for (int i = 0; i < NTAB; i++)
      if (tab_a[i] == a && tab_b[i] == b) fmul = tab_z[i];
  endfunction

  // Multiplier model: zero-wait operand acks, product one cycle after B.
  logic        hang = 1'b0;
  logic        busy;
  logic [31:0] ma, mb;
  assign mul_a_ack = mul_a_stb;
  assign mul_b_ack = mul_b_stb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0; mul_z_stb <= 1'b0; mul_z <= '0; ma <= '0; mb <= '0;
    end else if (mul_rst) begin
      busy <= 1'b0; mul_z_stb <= 1'b0;
    end else begin
      if (mul_a_stb && mul_a_ack) ma <= mul_a;
      if (mul_b_stb && mul_b_ack) begin mb <= mul_b; busy <= 1'b1; end
      if (busy && !hang) begin mul_z <= fmul(ma, mb); mul_z_stb <= 1'b1; busy <= 1'b0; end
      if (mul_z_stb && mul_z_ack) mul_z_stb <= 1'b0;
    end
  end

  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] z; logic err; } op_t;
  op_t ops_q[$];
  op_t exp_q[$];
  int  gnt_q[$];

  int n_chk = 0, n_fail = 0;
  int hold = 0, mrst_run = 0, n_mrst = 0, n_rsp = 0, cyc = 0, ack_cyc = 0;
  logic hold_bad = 1'b0, prev_zack = 1'b0;
  logic [NREQ-1:0] prev_rsp = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_op(input int id, input int t, input logic err);
    op_t o;
    o.id = id; o.a = tab_a[t]; o.b = tab_b[t];
    o.z = err ? 32'h7FC00000 : tab_z[t];
    o.err = err;
    ops_q.push_back(o);
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive requesters.
  task automatic step();
    int k;
    @(posedge clk); #1;
    cyc++;
    rsp_ack = '0;
    if (rsp_stb != 0) begin
      chk("rsp_onehot", $countones(rsp_stb), 1);
      if (prev_rsp == 0 && !rsp_err) chk("rsp_after_zack", prev_zack, 1);
      if (hold > 0) begin
        hold--;
        if (req_ack != 0 || mul_rst) hold_bad = 1'b1;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (rsp_stb[i]) begin
            k = -1;
            for (int e = 0; e < exp_q.size(); e++)
              if (k < 0 && exp_q[e].id == i) k = e;
            n_rsp++;
            if (k < 0) chk("rsp_unexpected_id", i, NREQ);
            else begin
              chk("rsp_z", rsp_z, exp_q[k].z);
              chk("rsp_err", rsp_err, exp_q[k].err);
              exp_q.delete(k);
            end
            rsp_ack[i] = 1'b1;
          end
        end
      end
    end
    if (mul_z_ack) chk("zack_pulse", prev_zack, 0);
    if (mul_rst) begin
      if (mrst_run == 0) begin
        n_mrst++;
        chk("wd_latency", (cyc - ack_cyc >= TIMEOUT) && (cyc - ack_cyc <= TIMEOUT + 1), 1);
      end
      mrst_run++;
    end else if (mrst_run > 0) begin
      chk("mul_rst_len", mrst_run, 2);
      mrst_run = 0;
    end
    if (req_ack != 0) begin
      chk("ack_onehot", $countones(req_ack), 1);
      chk("ack_with_astb", mul_a_stb, 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i]) begin
          chk("ack_had_stb", req_stb[i], 1);
          gnt_q.push_back(i);
          req_stb[i] = 1'b0;
          ack_cyc = cyc;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!req_stb[i]) begin
        for (int e = 0; e < ops_q.size(); e++) begin
          if (ops_q[e].id == i) begin
            req_a[32*i +: 32] = ops_q[e].a;
            req_b[32*i +: 32] = ops_q[e].b;
            req_stb[i] = 1'b1;
            exp_q.push_back(ops_q[e]);
            ops_q.delete(e);
            break;
          end
        end
      end
    end
    prev_zack = mul_z_ack;
    prev_rsp  = rsp_stb;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((ops_q.size() != 0 || exp_q.size() != 0 || req_stb != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  // ord holds expected grant ids as hex nibbles, first grant most significant.
  task automatic chk_gnt(input string tag, input int n, input logic [31:0] ord);
    logic [3:0] e;
    chk({tag, "_count"}, gnt_q.size(), n);
    for (int k = 0; k < n && k < gnt_q.size(); k++) begin
      e = ord[4*(n-1-k) +: 4];
      chk(tag, gnt_q[k], e);
    end
    gnt_q.delete();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ack"}, req_ack, 0);
    chk({tag, "_rsp_stb"}, rsp_stb, 0);
    chk({tag, "_rsp_z"}, rsp_z, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_mul_rst"}, mul_rst, 0);
    chk({tag, "_mul_stbs"}, {mul_a_stb, mul_b_stb, mul_z_ack}, 0);
    chk({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
  endtask

  initial begin
    int n, r0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_quiet("reset");
    rst = 1'b1;
    step();

    // All four requesters strobe together.
    add_op(0, 1, 1'b0); add_op(1, 2, 1'b0); add_op(2, 3, 1'b0); add_op(3, 4, 1'b0);
    drain(200);
    chk_gnt("gnt_all4", 4, 32'h0123);

    // Single request on requester 0: 2.0 x 3.0.
    add_op(0, 0, 1'b0);
    drain(50);
    chk_gnt("gnt_single", 1, 32'h0);

    // Requester 1 streams, requester 2 strobes once (ptr is 1 here).
    add_op(1, 5, 1'b0); add_op(2, 6, 1'b0);
    add_op(1, 7, 1'b0); add_op(1, 0, 1'b0); add_op(1, 1, 1'b0);
    drain(400);
    chk_gnt("gnt_stream", 5, 32'h12111);

    // Hung multiplier on requester 3, then a normal op on requester 0.
    hang = 1'b1;
    add_op(3, 2, 1'b1);
    drain(TIMEOUT + 40);
    chk("wd_pulses", n_mrst, 1);
    hang = 1'b0;
    add_op(0, 3, 1'b0);
    drain(50);
    chk_gnt("gnt_after_wd", 2, 32'h30);

    // Result held for 50 cycles while requester 2 waits.
    add_op(1, 4, 1'b0); add_op(2, 5, 1'b0);
    hold = 50; hold_bad = 1'b0;
    drain(200);
    chk("hold_clean", hold_bad, 0);
    chk("hold_elapsed", hold, 0);
    chk_gnt("gnt_hold", 2, 32'h12);

    // Reset during WAIT_Z on requester 1 (ptr 3 -> grant 1 -> ptr 2).
    hang = 1'b1;
    add_op(1, 6, 1'b0);
    n = 0;
    while (gnt_q.size() == 0 && n < 20) begin step(); n++; end
    chk("rst_test_grant", gnt_q.size(), 1);
    repeat (3) step();
    #2 rst = 1'b0;
    #1 chk_quiet("midop_reset");
    exp_q.delete(); ops_q.delete(); gnt_q.delete();
    req_stb = '0; hang = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    r0 = n_rsp;
    repeat (10) step();
    chk("no_rsp_after_rst", n_rsp - r0, 0);
    add_op(1, 7, 1'b0); add_op(3, 0, 1'b0);
    drain(100);
    chk_gnt("gnt_after_rst", 2, 32'h13);
    chk("wd_total", n_mrst, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
